// File: rtl/uart_pkg.sv
// Shared constants, state encoding and width helper for the UART transmit frame engine.
package uart_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;
   localparam int unsigned PARITY_ODD  = 2;

   localparam logic [2:0] IDLE_ENC      = 3'd0;
   localparam logic [2:0] READ_ENC      = 3'd1;
   localparam logic [2:0] WAIT_DATA_ENC = 3'd2;
   localparam logic [2:0] START_ENC     = 3'd3;
   localparam logic [2:0] DATA_ENC      = 3'd4;
   localparam logic [2:0] PARITY_ENC    = 3'd5;
   localparam logic [2:0] STOP_ENC      = 3'd6;

   typedef enum logic [2:0] {
      StIdle     = IDLE_ENC,
      StRead     = READ_ENC,
      StWaitData = WAIT_DATA_ENC,
      StStart    = START_ENC,
      StData     = DATA_ENC,
      StParity   = PARITY_ENC,
      StStop     = STOP_ENC
   } state_e;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 50
) (
   input  logic clk,
   input  logic reset_b,
   input  logic clr,
   input  logic en,
   output logic bit_end
);

   localparam int unsigned     CntW    = cnt_width(CLKS_PER_BIT);
   localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign bit_end = en && (cnt_q == LastCnt);

   always_comb begin
      cnt_d = cnt_q;
      if (clr || bit_end) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_frame_engine.sv
// UART transmit engine: pops one word from the upstream FIFO and serialises it as
// start, LSB-first data, optional parity and 1-2 stop bits. All outputs are registered.
module uart_tx_frame_engine
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = 50,
   parameter int unsigned PARITY_MODE  = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset_b,
   input  logic                 empty,
   input  logic                 data_valid,
   input  logic [DATA_BITS-1:0] fifo_data,
   output logic                 read_en,
   output logic                 tx,
   output logic                 busy,
   output logic                 frame_done
);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $fatal(1, "uart_tx_frame_engine: DATA_BITS must be 5..9");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $fatal(1, "uart_tx_frame_engine: CLKS_PER_BIT must be >= 2");
   end
   if (PARITY_MODE > PARITY_ODD) begin : g_bad_parity_mode
      $fatal(1, "uart_tx_frame_engine: PARITY_MODE must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $fatal(1, "uart_tx_frame_engine: STOP_BITS must be 1 or 2");
   end

   localparam int unsigned     IdxW     = cnt_width(DATA_BITS);
   localparam logic [IdxW-1:0] LastBit  = IdxW'(DATA_BITS - 1);
   localparam logic            LastStop = 1'(STOP_BITS - 1);

   state_e                 state_q, state_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [IdxW-1:0]        bit_idx_q, bit_idx_d;
   logic                   stop_idx_q, stop_idx_d;
   logic                   parity_q, parity_d;
   logic                   tx_q, tx_d;
   logic                   read_en_q, read_en_d;
   logic                   busy_q, busy_d;
   logic                   frame_done_q, frame_done_d;
   logic                   tick_en, bit_end;

   assign tick_en = state_q inside {StStart, StData, StParity, StStop};

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_tick (
      .clk     (clk),
      .reset_b (reset_b),
      .clr     (!tick_en),
      .en      (tick_en),
      .bit_end (bit_end)
   );

   // tx_d is the value for the bit being entered, so tx changes on the same edge as the state.
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_idx_d    = bit_idx_q;
      stop_idx_d   = stop_idx_q;
      parity_d     = parity_q;
      tx_d         = tx_q;
      read_en_d    = 1'b0;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      case (state_q)
         StIdle: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (!empty) begin
               state_d   = StRead;
               read_en_d = 1'b1;
               busy_d    = 1'b1;
            end
         end
         StRead: state_d = StWaitData;
         StWaitData: begin
            if (data_valid) begin
               shift_d    = fifo_data;
               parity_d   = (^fifo_data) ^ (PARITY_MODE == PARITY_ODD);
               bit_idx_d  = '0;
               stop_idx_d = 1'b0;
               tx_d       = 1'b0;
               state_d    = StStart;
            end
         end
         StStart: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               state_d = StData;
            end
         end
         StData: begin
            if (bit_end) begin
               if (bit_idx_q != LastBit) begin
                  bit_idx_d = bit_idx_q + 1'b1;
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
               end else if (PARITY_MODE != PARITY_NONE) begin
                  tx_d    = parity_q;
                  state_d = StParity;
               end else begin
                  tx_d    = 1'b1;
                  state_d = StStop;
               end
            end
         end
         StParity: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               state_d = StStop;
            end
         end
         StStop: begin
            if (bit_end) begin
               if (stop_idx_q == LastStop) begin
                  frame_done_d = 1'b1;
                  busy_d       = 1'b0;
                  state_d      = StIdle;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q      <= StIdle;
         shift_q      <= '0;
         bit_idx_q    <= '0;
         stop_idx_q   <= 1'b0;
         parity_q     <= 1'b0;
         tx_q         <= 1'b1;
         read_en_q    <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_idx_q    <= bit_idx_d;
         stop_idx_q   <= stop_idx_d;
         parity_q     <= parity_d;
         tx_q         <= tx_d;
         read_en_q    <= read_en_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign tx         = tx_q;
   assign read_en    = read_en_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule
